// File: rtl/noc_traffic_pkg.sv
// Shared constants and types for the NoC traffic-generator sequencer.
package noc_traffic_pkg;

  localparam int DEF_NUM_VC       = 4;
  localparam int DEF_VC_W         = 2;
  localparam int DEF_CREDIT_DEPTH = 4;
  localparam int DEF_CNT_W        = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int OP_W             = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_INIT = 3'd5;
  localparam logic [OP_W-1:0] OP_FILL = 3'd6;
  localparam logic [OP_W-1:0] OP_DEQ  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/credit_counter_bank.sv
// Per-VC saturating credit counters for the router input port.
module credit_counter_bank #(
  parameter int NUM_VC       = 4,
  parameter int VC_W         = 2,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              consume_valid,
  input  logic [VC_W-1:0]   consume_vc,
  input  logic              return_valid,
  input  logic [VC_W-1:0]   return_vc,
  output logic [NUM_VC-1:0] nonzero,
  output logic              overflow
);

  localparam int CRD_W = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CRD_W-1:0] FULL = CRD_W'(CREDIT_DEPTH);

  logic [CRD_W-1:0] credit_q [NUM_VC];
  logic [CRD_W-1:0] credit_d [NUM_VC];

  always_comb begin
    overflow = 1'b0;
    nonzero  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_d[v] = credit_q[v];
      nonzero[v]  = (credit_q[v] != '0);
      if (reload) begin
        credit_d[v] = FULL;
      end else if (consume_valid && consume_vc == VC_W'(v) &&
                   !(return_valid && return_vc == VC_W'(v))) begin
        credit_d[v] = credit_q[v] - CRD_W'(1);
      end else if (return_valid && return_vc == VC_W'(v) &&
                   !(consume_valid && consume_vc == VC_W'(v))) begin
        // A return to a full counter means the router handed back a slot we never used.
        if (credit_q[v] == FULL) overflow = 1'b1;
        else                     credit_d[v] = credit_q[v] + CRD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (rst) credit_q[v] <= FULL;
      else     credit_q[v] <= credit_d[v];
    end
  end

endmodule

// File: rtl/traffic_inject_ctrl.sv
// Sequences Init/Fill/Dequeue commands to one traffic generator, gating
// Dequeues on per-VC router credits.
//
// state | meaning
// IDLE  | waiting for start after reset
// INIT  | one cycle: issue Init with the packet count, reload credits
// FILL  | accept one descriptor per packet, forward each as Fill
// RUN   | alternate ISSUE/GAP cycles, Dequeue when the next VC has credit
// DONE  | run finished, run_done held until the next start
module traffic_inject_ctrl
  import noc_traffic_pkg::*;
#(
  parameter int NUM_VC       = DEF_NUM_VC,
  parameter int VC_W         = DEF_VC_W,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  total_packets,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic [OP_W-1:0]   gen_op,
  output logic [DATA_W-1:0] gen_data,
  input  logic              gen_done,
  input  logic [VC_W-1:0]   gen_next_vc,
  output logic              flit_valid,
  output logic [VC_W-1:0]   flit_vc,
  input  logic              credit_ret_valid,
  input  logic [VC_W-1:0]   credit_ret_vc,
  output logic              busy,
  output logic              run_done,
  output logic              credit_err
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              gap_q, gap_d;
  logic [OP_W-1:0]   gen_op_q, gen_op_d;
  logic [DATA_W-1:0] gen_data_q, gen_data_d;
  logic              flit_valid_q, flit_valid_d;
  logic [VC_W-1:0]   flit_vc_q, flit_vc_d;
  logic              run_done_q, run_done_d;
  logic              credit_err_q, credit_err_d;

  logic              consume;
  logic              reload;
  logic [NUM_VC-1:0] credit_nz;
  logic              credit_ovf;

  credit_counter_bank #(
    .NUM_VC       (NUM_VC),
    .VC_W         (VC_W),
    .CREDIT_DEPTH (CREDIT_DEPTH)
  ) u_credits (
    .clk           (clk),
    .rst           (rst),
    .reload        (reload),
    .consume_valid (consume),
    .consume_vc    (gen_next_vc),
    .return_valid  (credit_ret_valid),
    .return_vc     (credit_ret_vc),
    .nonzero       (credit_nz),
    .overflow      (credit_ovf)
  );

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    fill_cnt_d   = fill_cnt_q;
    gap_d        = 1'b0;
    gen_op_d     = OP_NOP;
    gen_data_d   = gen_data_q;
    flit_valid_d = (gen_op_q == OP_DEQ);
    flit_vc_d    = flit_vc_q;
    run_done_d   = run_done_q;
    credit_err_d = credit_err_q | credit_ovf;
    consume      = 1'b0;
    reload       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          total_d    = total_packets;
          run_done_d = 1'b0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        gen_op_d   = OP_INIT;
        gen_data_d = DATA_W'(total_q);
        reload     = 1'b1;
        fill_cnt_d = '0;
        if (total_q == '0) begin
          state_d    = S_DONE;
          run_done_d = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (cfg_valid) begin
          gen_op_d   = OP_FILL;
          gen_data_d = cfg_data;
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          if (fill_cnt_d == total_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // GAP cycles give the generator time to update gen_next_vc.
        if (!gap_q) begin
          if (gen_done) begin
            state_d    = S_DONE;
            run_done_d = 1'b1;
          end else if (credit_nz[gen_next_vc]) begin
            gen_op_d  = OP_DEQ;
            consume   = 1'b1;
            flit_vc_d = gen_next_vc;
            gap_d     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      total_q      <= '0;
      fill_cnt_q   <= '0;
      gap_q        <= 1'b0;
      gen_op_q     <= OP_NOP;
      gen_data_q   <= '0;
      flit_valid_q <= 1'b0;
      flit_vc_q    <= '0;
      run_done_q   <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      fill_cnt_q   <= fill_cnt_d;
      gap_q        <= gap_d;
      gen_op_q     <= gen_op_d;
      gen_data_q   <= gen_data_d;
      flit_valid_q <= flit_valid_d;
      flit_vc_q    <= flit_vc_d;
      run_done_q   <= run_done_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign cfg_ready  = (state_q == S_FILL);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign gen_op     = gen_op_q;
  assign gen_data   = gen_data_q;
  assign flit_valid = flit_valid_q;
  assign flit_vc    = flit_vc_q;
  assign run_done   = run_done_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_traffic_inject_ctrl.sv
// Bench for traffic_inject_ctrl: vector table, directed credit sequences and
// randomized traffic against a transaction-level reference model.
module tb_traffic_inject_ctrl;

  localparam logic [2:0] OPN = 3'd0;
  localparam logic [2:0] OPI = 3'd5;
  localparam logic [2:0] OPF = 3'd6;
  localparam logic [2:0] OPD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  total_packets = '0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready;
  logic [2:0]  gen_op;
  logic [31:0] gen_data;
  logic        gen_done = 1'b0;
  logic [1:0]  gen_next_vc = '0;
  logic        flit_valid;
  logic [1:0]  flit_vc;
  logic        credit_ret_valid = 1'b0;
  logic [1:0]  credit_ret_vc = '0;
  logic        busy;
  logic        run_done;
  logic        credit_err;

  traffic_inject_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .total_packets    (total_packets),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_ready        (cfg_ready),
    .gen_op           (gen_op),
    .gen_data         (gen_data),
    .gen_done         (gen_done),
    .gen_next_vc      (gen_next_vc),
    .flit_valid       (flit_valid),
    .flit_vc          (flit_vc),
    .credit_ret_valid (credit_ret_valid),
    .credit_ret_vc    (credit_ret_vc),
    .busy             (busy),
    .run_done         (run_done),
    .credit_err       (credit_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: packets still to be filled, credits per VC, and whether the
  // previous command was a Dequeue (which forces a quiet cycle before the next).
  logic [9:0]  m_total;
  bit          m_init, m_running, m_gap, m_err, m_run_done, m_rst;
  int          m_fills;
  int          m_cr [4];
  logic [2:0]  e_op;
  logic [31:0] e_data;
  bit          e_fv;
  logic [1:0]  e_fvc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         consume, reload;
    int         cvc, rv;
    logic [2:0] op;
    consume = 0; reload = 0; cvc = 0; op = OPN;
    if (rst) begin
      m_rst = 1; m_init = 0; m_running = 0; m_gap = 0; m_err = 0; m_run_done = 0;
      m_fills = 0; m_total = '0;
      foreach (m_cr[v]) m_cr[v] = 4;
      e_op = OPN; e_data = '0; e_fv = 0; e_fvc = '0;
      return;
    end
    m_rst = 0;
    e_fv = (e_op == OPD);
    if (m_init) begin
      op = OPI; e_data = 32'(m_total); reload = 1;
      m_fills = int'(m_total); m_init = 0;
      if (m_total == 0) m_run_done = 1;
    end else if (m_fills > 0) begin
      if (cfg_valid) begin
        op = OPF; e_data = cfg_data; m_fills--;
        if (m_fills == 0) begin m_running = 1; m_gap = 0; end
      end
    end else if (m_running) begin
      if (m_gap) m_gap = 0;
      else if (gen_done) begin m_running = 0; m_run_done = 1; end
      else if (m_cr[gen_next_vc] > 0) begin
        op = OPD; consume = 1; cvc = int'(gen_next_vc); e_fvc = gen_next_vc; m_gap = 1;
      end
    end else if (start) begin
      m_total = total_packets; m_init = 1; m_run_done = 0;
    end
    if (reload) begin
      foreach (m_cr[v]) m_cr[v] = 4;
    end else begin
      rv = int'(credit_ret_vc);
      if (credit_ret_valid && !(consume && cvc == rv)) begin
        if (m_cr[rv] == 4) m_err = 1;
        else m_cr[rv]++;
      end
      if (consume && !(credit_ret_valid && cvc == rv)) m_cr[cvc]--;
    end
    e_op = op;
  endtask

  task automatic model_compare();
    check("gen_op", 32'(gen_op), 32'(e_op));
    check("cfg_ready", 32'(cfg_ready), 32'(m_fills > 0));
    check("busy", 32'(busy), 32'(m_init || m_fills > 0 || m_running));
    check("run_done", 32'(run_done), 32'(m_run_done));
    check("credit_err", 32'(credit_err), 32'(m_err));
    check("flit_valid", 32'(flit_valid), 32'(e_fv));
    if (e_op == OPI || e_op == OPF || m_rst) check("gen_data", gen_data, e_data);
    if (e_fv || m_rst) check("flit_vc", 32'(flit_vc), 32'(e_fvc));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_compare();
  endtask

  task automatic do_setup(input logic [9:0] n);
    start = 1; total_packets = n; tick();
    start = 0; tick();
    for (int i = 0; i < int'(n); i++) begin
      cfg_valid = 1; cfg_data = $urandom; tick();
    end
    cfg_valid = 0;
  endtask

  typedef struct {
    bit          start;
    logic [9:0]  total;
    bit          cv;
    logic [31:0] cd;
    bit          gd;
    logic [2:0]  op;
    bit          chk_d;
    logic [31:0] d;
    bit          rdy;
    bit          bsy;
    bit          rdn;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ndeq, nfl, last, nop;

    tbl[0] = '{1, 10'd3, 0, 32'h0,        0, OPN, 0, 32'h0,        0, 1, 0};
    tbl[1] = '{0, 10'd3, 0, 32'h0,        0, OPI, 1, 32'h3,        1, 1, 0};
    tbl[2] = '{0, 10'd3, 1, 32'hA1A1_0001, 0, OPF, 1, 32'hA1A1_0001, 1, 1, 0};
    tbl[3] = '{0, 10'd3, 0, 32'h0,        0, OPN, 0, 32'h0,        1, 1, 0};
    tbl[4] = '{0, 10'd3, 1, 32'hB2B2_0002, 0, OPF, 1, 32'hB2B2_0002, 1, 1, 0};
    tbl[5] = '{0, 10'd3, 1, 32'hC3C3_0003, 0, OPF, 1, 32'hC3C3_0003, 0, 1, 0};
    tbl[6] = '{0, 10'd3, 0, 32'h0,        1, OPN, 0, 32'h0,        0, 0, 1};
    tbl[7] = '{0, 10'd3, 1, 32'hDEAD_BEEF, 0, OPN, 0, 32'h0,        0, 0, 1};

    rst = 1;
    repeat (3) tick();
    check("rst_gen_op", 32'(gen_op), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_run_done", 32'(run_done), 0);
    rst = 0;
    tick();

    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start; total_packets = tbl[i].total;
      cfg_valid = tbl[i].cv; cfg_data = tbl[i].cd; gen_done = tbl[i].gd;
      tick();
      check($sformatf("tbl%0d_op", i), 32'(gen_op), 32'(tbl[i].op));
      if (tbl[i].chk_d) check($sformatf("tbl%0d_data", i), gen_data, tbl[i].d);
      check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("tbl%0d_run_done", i), 32'(run_done), 32'(tbl[i].rdn));
    end
    start = 0; cfg_valid = 0; gen_done = 0;

    // Credit exhaustion on VC2.
    gen_next_vc = 2;
    do_setup(1);
    ndeq = 0; nfl = 0; last = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (gen_op == OPD) begin ndeq++; last = t; end
      if (flit_valid && flit_vc == 2) nfl++;
    end
    check("exh_deq_count", ndeq, 4);
    check("exh_flit_count", nfl, 4);
    check("exh_last_deq", last, 7);

    credit_ret_valid = 1; credit_ret_vc = 2; tick();
    credit_ret_valid = 0;
    ndeq = (gen_op == OPD) ? 1 : 0;
    tick();
    ndeq += (gen_op == OPD) ? 1 : 0;
    check("ret_redeq_count", ndeq, 1);
    check("ret_redeq_timing", 32'(gen_op), 32'(OPD));

    // Same-cycle consume and return on VC1 when its credit is 1.
    gen_next_vc = 1;
    ndeq = 0;
    for (int t = 0; t < 20 && ndeq < 3; t++) begin
      tick();
      if (gen_op == OPD) ndeq++;
    end
    check("vc1_three_deq", ndeq, 3);
    tick();
    credit_ret_valid = 1; credit_ret_vc = 1; tick();
    credit_ret_valid = 0;
    check("same_cycle_deq", 32'(gen_op), 32'(OPD));
    ndeq = 0;
    repeat (8) begin
      tick();
      if (gen_op == OPD) ndeq++;
    end
    check("after_same_cycle_deq", ndeq, 1);

    // Return to a full VC0.
    credit_ret_valid = 1; credit_ret_vc = 0; tick();
    credit_ret_valid = 0;
    check("credit_err_set", 32'(credit_err), 1);
    repeat (3) tick();
    check("credit_err_sticky", 32'(credit_err), 1);

    // gen_done while credit is available on the next VC.
    gen_next_vc = 3; gen_done = 1; tick();
    gen_done = 0;
    check("done_no_deq", 32'(gen_op), 0);
    check("done_run_done", 32'(run_done), 1);
    ndeq = 0;
    repeat (4) begin
      tick();
      if (gen_op == OPD) ndeq++;
    end
    check("done_quiet", ndeq, 0);

    // Restart from DONE, then reset in the middle of RUN.
    start = 1; total_packets = 2; tick();
    start = 0; tick();
    check("restart_init", 32'(gen_op), 32'(OPI));
    check("restart_data", gen_data, 2);
    check("err_survives_start", 32'(credit_err), 1);
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1; cfg_data = $urandom; tick();
    end
    cfg_valid = 0; gen_next_vc = 0;
    ndeq = 0;
    for (int t = 0; t < 6 && ndeq < 1; t++) begin
      tick();
      if (gen_op == OPD) ndeq++;
    end
    check("midrun_deq_seen", ndeq, 1);
    rst = 1; tick();
    check("midrst_gen_op", 32'(gen_op), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_flit_valid", 32'(flit_valid), 0);
    check("midrst_credit_err", 32'(credit_err), 0);
    rst = 0; tick();

    // Zero-packet run.
    start = 1; total_packets = 0; tick();
    start = 0; tick();
    check("zp_init", 32'(gen_op), 32'(OPI));
    check("zp_data", gen_data, 0);
    check("zp_run_done", 32'(run_done), 1);
    check("zp_busy", 32'(busy), 0);
    nop = 0;
    cfg_valid = 1;
    repeat (4) begin
      tick();
      if (gen_op != OPN) nop++;
    end
    cfg_valid = 0;
    check("zp_no_cmds", nop, 0);

    // Randomized traffic against the model.
    repeat (700) begin
      start            = ($urandom_range(0, 15) == 0);
      total_packets    = 10'($urandom_range(0, 4));
      cfg_valid        = 1'($urandom);
      cfg_data         = $urandom;
      gen_done         = ($urandom_range(0, 9) == 0);
      gen_next_vc      = 2'($urandom);
      credit_ret_valid = ($urandom_range(0, 5) == 0);
      credit_ret_vc    = 2'($urandom);
      rst              = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 0; start = 0; cfg_valid = 0; gen_done = 0; credit_ret_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_inject_ctrl.md
Name: traffic_inject_ctrl

Overview:
Sequencer and flow-control gate for one NoC traffic generator. Issues the generator's op/data commands: one Init, then one Fill per packet descriptor from a config stream, then Dequeue commands gated by per-VC credits from the downstream router input port. Sits between the testbench/config source, the traffic generator and the router's credit return path.

Parameters:
NUM_VC, 4, number of virtual channels at the router input
VC_W, 2, VC index width (log2 NUM_VC)
CREDIT_DEPTH, 4, flit buffer depth per VC at the router; reset credit value
CNT_W, 10, packet count width
DATA_W, 32, generator data bus width
OP_W, 3, generator opcode width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin a run
total_packets  in  CNT_W  packets in this run; sampled on start
cfg_valid  in  1  packet descriptor valid
cfg_data  in  DATA_W  descriptor {dst, vc, num_flits}, passed through unchanged
cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready
gen_op  out  OP_W  registered command to generator
gen_data  out  DATA_W  registered data to generator
gen_done  in  1  generator done flag
gen_next_vc  in  VC_W  VC of the generator's next flit
flit_valid  out  1  pulse: generator presents a new flit this cycle
flit_vc  out  VC_W  VC of that flit
credit_ret_valid  in  1  router freed one slot
credit_ret_vc  in  VC_W  VC of the freed slot
busy  out  1  state not IDLE/DONE
run_done  out  1  run complete, held until next start or rst
credit_err  out  1  sticky: credit return overflow

Behaviour:
- Opcodes: NOP=0, Init=5, Fill=6, Dequeue=7.
- Reset, and every cycle rst is high, including mid-run: state IDLE; gen_op=NOP; gen_data=0; cfg_ready=0; flit_valid=0; flit_vc=0; busy=0; run_done=0; credit_err=0; all credits=CREDIT_DEPTH; counters=0.
- IDLE: gen_op=NOP. On start: latch total_packets, go to INIT.
- DONE: gen_op=NOP. start re-enters INIT and clears run_done. start in any other state is ignored.
- INIT: for exactly 1 cycle, gen_op=Init and gen_data={0, total_packets}. Credits reload to CREDIT_DEPTH; fill_cnt=0. Go to DONE if total_packets==0, otherwise go to FILL.
- FILL:
  - cfg_ready=1 (combinational from state).
  - On each accepted beat: next cycle gen_op=Fill, gen_data=cfg_data, fill_cnt+1. A cycle with no beat gives gen_op=NOP.
  - When the beat taking fill_cnt to total_packets is accepted, go to RUN; cfg_ready=0 from the next cycle.
- RUN:
  - Two-phase issue. ISSUE cycle: if !gen_done and credit[gen_next_vc]>0, register gen_op=Dequeue, decrement credit[gen_next_vc], latch flit_vc=gen_next_vc. GAP cycle: gen_op=NOP.
  - flit_valid pulses 1 cycle after the Dequeue cycle, with flit_vc.
  - Maximum rate is 1 Dequeue per 2 cycles. The gap lets gen_next_vc settle.
  - No credit: hold NOP and re-evaluate every cycle.
  - gen_done high in an ISSUE cycle: go to DONE; run_done=1 next cycle.
- Credits:
  - Each VC has a 0..CREDIT_DEPTH counter, width clog2(CREDIT_DEPTH+1).
  - A return increments the counter for credit_ret_vc.
  - Consume and return on the same VC in the same cycle: net unchanged, valid even when the counter is 0.
  - A return to a counter already at CREDIT_DEPTH saturates and sets credit_err, which stays set until rst.
  - Returns are accepted in every state except reset.
- All outputs except cfg_ready and busy are registered.

Decomposition:
- noc_traffic_pkg:
  - opcode constants NOP/Init/Fill/Dequeue
  - state enum IDLE/INIT/FILL/RUN/DONE
  - default widths VC_W, CNT_W, DATA_W
- credit_counter_bank: one sub-module with NUM_VC saturating counters.
  - Inputs: consume_valid/vc, return_valid/vc, reload.
  - Outputs: per-VC nonzero vector, overflow pulse.

Test Plan:
- Reset: hold rst 3 cycles -> gen_op=0, cfg_ready=0, run_done=0, all credits=4. Assert rst mid-RUN -> next cycle gen_op=0, busy=0, credits=4.
- Setup sequence: start, total_packets=3, cfg beats at cycles 2,4,5 -> gen_op=5 for exactly 1 cycle, then gen_op=6 exactly 3 times with matching gen_data, cfg_ready=0 after the 3rd beat.
- Credit exhaustion: gen_next_vc=2 constant, no returns -> exactly 4 Dequeues 2 cycles apart, then NOP. One return on VC2 -> one more Dequeue within 2 cycles; flit_valid/flit_vc=2 one cycle after each Dequeue.
- Credit timing: credit[1]=1 with consume and return on VC1 in the same cycle -> credit[1] stays 1. Return on a full VC0 -> credit_err=1 and stays set.
- Zero-packet run: total_packets=0 -> Init, then DONE, run_done=1, no Fill or Dequeue issued.
- Completion: gen_done rises during RUN -> no further Dequeue, run_done=1 next cycle. A new start restarts from INIT.
